// File: rtl/ex_stage_muldiv.sv
// Execute stage: operand forwarding, ALU, branch/jump targets, plus an
// iterative radix-2 multiply / restoring divide unit with HI/LO registers.
module ex_stage_muldiv #(
  parameter int NBits   = 32,
  parameter int CntBits = $clog2(NBits) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ShamtSelector,
  input  logic               ALUSrc,
  input  logic [NBits-1:0]   ReadData1,
  input  logic [NBits-1:0]   ReadData2,
  input  logic [NBits-1:0]   ShamtExtend,
  input  logic [NBits-1:0]   InmmediateExtend,
  input  logic [2:0]         ALUOp,
  input  logic [5:0]         ALUFunction,
  input  logic               RType,
  input  logic               Flush,
  input  logic [25:0]        JumpNoShifted,
  input  logic [NBits-1:0]   PC_4,
  input  logic [1:0]         ForwardA,
  input  logic [1:0]         ForwardB,
  input  logic [NBits-1:0]   ALUMemOrPCData,
  input  logic [NBits-1:0]   MEM_ALUResult,
  output logic [NBits-1:0]   WriteData,
  output logic [NBits-1:0]   BranchAddress,
  output logic [NBits-1:0]   JumpAddress,
  output logic [NBits-1:0]   ALUResult,
  output logic               Zero,
  output logic               MulDivBusy,
  output logic               Stall,
  output logic [NBits-1:0]   HI,
  output logic [NBits-1:0]   LO
);

  localparam logic [5:0] FnMfhi  = 6'h10;
  localparam logic [5:0] FnMthi  = 6'h11;
  localparam logic [5:0] FnMflo  = 6'h12;
  localparam logic [5:0] FnMtlo  = 6'h13;
  localparam logic [5:0] FnMult  = 6'h18;
  localparam logic [5:0] FnMultu = 6'h19;
  localparam logic [5:0] FnDiv   = 6'h1A;
  localparam logic [5:0] FnDivu  = 6'h1B;

  typedef enum logic [3:0] {
    AluAdd, AluSub, AluAnd, AluOr, AluXor, AluNor,
    AluSlt, AluSltu, AluSll, AluSrl, AluSra, AluLui
  } aluCtl_t;

  typedef enum logic [1:0] {Idle, MulRun, DivRun} mdState_t;

  logic [NBits-1:0] rsFwd, rtFwd, aluA, aluB, aluOut;
  logic [4:0]       shamt;
  aluCtl_t          aluCtl;

  always_comb begin
    case (ForwardA)
      2'd1:    rsFwd = ALUMemOrPCData;
      2'd2:    rsFwd = MEM_ALUResult;
      default: rsFwd = ReadData1;
    endcase
    case (ForwardB)
      2'd1:    rtFwd = ALUMemOrPCData;
      2'd2:    rtFwd = MEM_ALUResult;
      default: rtFwd = ReadData2;
    endcase
  end

  assign aluA          = ShamtSelector ? ShamtExtend : rsFwd;
  assign aluB          = ALUSrc ? InmmediateExtend : rtFwd;
  assign WriteData     = rtFwd;
  assign BranchAddress = PC_4 + (InmmediateExtend << 2);
  assign JumpAddress   = {PC_4[NBits-1:28], JumpNoShifted, 2'b00};

  // ALUOp 7 selects the R-type funct decode; other codes are immediate-class ops.
  always_comb begin
    aluCtl = AluAdd;
    case (ALUOp)
      3'd0: aluCtl = AluAdd;
      3'd1: aluCtl = AluSub;
      3'd2: aluCtl = AluAnd;
      3'd3: aluCtl = AluOr;
      3'd4: aluCtl = AluLui;
      3'd5: aluCtl = AluSlt;
      3'd6: aluCtl = AluXor;
      default: begin
        case (ALUFunction)
          6'h20, 6'h21: aluCtl = AluAdd;
          6'h22, 6'h23: aluCtl = AluSub;
          6'h24:        aluCtl = AluAnd;
          6'h25:        aluCtl = AluOr;
          6'h26:        aluCtl = AluXor;
          6'h27:        aluCtl = AluNor;
          6'h2A:        aluCtl = AluSlt;
          6'h2B:        aluCtl = AluSltu;
          6'h00, 6'h04: aluCtl = AluSll;
          6'h02, 6'h06: aluCtl = AluSrl;
          6'h03, 6'h07: aluCtl = AluSra;
          default:      aluCtl = AluAdd;
        endcase
      end
    endcase
  end

  always_comb begin
    shamt  = aluA[4:0];
    aluOut = '0;
    case (aluCtl)
      AluAdd:  aluOut = aluA + aluB;
      AluSub:  aluOut = aluA - aluB;
      AluAnd:  aluOut = aluA & aluB;
      AluOr:   aluOut = aluA | aluB;
      AluXor:  aluOut = aluA ^ aluB;
      AluNor:  aluOut = ~(aluA | aluB);
      AluSlt:  aluOut = {{(NBits-1){1'b0}}, ($signed(aluA) < $signed(aluB))};
      AluSltu: aluOut = {{(NBits-1){1'b0}}, (aluA < aluB)};
      AluSll:  aluOut = aluB << shamt;
      AluSrl:  aluOut = aluB >> shamt;
      AluSra:  aluOut = $unsigned($signed(aluB) >>> shamt);
      AluLui:  aluOut = aluB << 16;
      default: aluOut = aluA + aluB;
    endcase
  end

  logic isMfhi, isMthi, isMflo, isMtlo, isMul, isDiv, mdHit, accept;
  logic startMul, startDiv, signedOp, sA, sB, lastStep;
  logic [NBits-1:0] absA, absB;

  assign isMfhi   = RType && (ALUFunction == FnMfhi);
  assign isMthi   = RType && (ALUFunction == FnMthi);
  assign isMflo   = RType && (ALUFunction == FnMflo);
  assign isMtlo   = RType && (ALUFunction == FnMtlo);
  assign isMul    = RType && ((ALUFunction == FnMult) || (ALUFunction == FnMultu));
  assign isDiv    = RType && ((ALUFunction == FnDiv) || (ALUFunction == FnDivu));
  assign mdHit    = isMfhi | isMthi | isMflo | isMtlo | isMul | isDiv;
  assign Stall    = MulDivBusy & mdHit;
  assign accept   = mdHit & ~Flush & ~Stall;
  assign startMul = accept & isMul;
  assign startDiv = accept & isDiv;

  // Signed variants have an even funct code; unsigned ones set bit 0.
  assign signedOp = ~ALUFunction[0];
  assign sA       = signedOp & rsFwd[NBits-1];
  assign sB       = signedOp & rtFwd[NBits-1];
  assign absA     = sA ? -rsFwd : rsFwd;
  assign absB     = sB ? -rtFwd : rtFwd;

  mdState_t             state, stateNext;
  logic [CntBits-1:0]   cnt;
  logic [2*NBits-1:0]   acc;
  logic [NBits-1:0]     opB;
  logic                 negRes, negRem, divZero;

  assign MulDivBusy = (state != Idle);
  assign lastStep   = MulDivBusy && (cnt == CntBits'(1));

  always_ff @(posedge clk) begin
    if (reset) state <= Idle;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      Idle: begin
        if (startMul)      stateNext = MulRun;
        else if (startDiv) stateNext = DivRun;
      end
      MulRun, DivRun: begin
        if (lastStep) stateNext = Idle;
      end
      default: stateNext = Idle;
    endcase
  end

  // One iteration step: acc holds {partial product, multiplier} for MUL and
  // {remainder, dividend/quotient} for DIV, so both share one shift register.
  logic [NBits:0]       mulSum, divTrial;
  logic [NBits-1:0]     divDiff, quoRaw, remRaw, quoFinal, remFinal;
  logic                 divFits;
  logic [2*NBits-1:0]   mulNext, divNext, prodFinal;

  always_comb begin
    mulSum    = {1'b0, acc[2*NBits-1:NBits]} +
                (acc[0] ? {1'b0, opB} : {(NBits+1){1'b0}});
    mulNext   = {mulSum, acc[NBits-1:1]};
    divTrial  = {acc[2*NBits-1:NBits], acc[NBits-1]};
    divFits   = (divTrial >= {1'b0, opB});
    divDiff   = divFits ? NBits'(divTrial - {1'b0, opB}) : divTrial[NBits-1:0];
    divNext   = {divDiff, acc[NBits-2:0], divFits};
    prodFinal = negRes ? -mulNext : mulNext;
    quoRaw    = divNext[NBits-1:0];
    remRaw    = divNext[2*NBits-1:NBits];
    quoFinal  = divZero ? '1 : (negRes ? -quoRaw : quoRaw);
    remFinal  = negRem ? -remRaw : remRaw;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      acc     <= '0;
      opB     <= '0;
      negRes  <= 1'b0;
      negRem  <= 1'b0;
      divZero <= 1'b0;
    end else if (startMul | startDiv) begin
      acc     <= {{NBits{1'b0}}, absA};
      opB     <= absB;
      cnt     <= CntBits'(NBits);
      negRes  <= sA ^ sB;
      negRem  <= sA;
      divZero <= (rtFwd == '0);
    end else if (MulDivBusy && (cnt != '0)) begin
      acc <= (state == MulRun) ? mulNext : divNext;
      cnt <= cnt - CntBits'(1);
    end
  end

  // HI/LO only change on the final iteration or on an accepted MTHI/MTLO.
  always_ff @(posedge clk) begin
    if (reset) begin
      HI <= '0;
      LO <= '0;
    end else if (lastStep) begin
      if (state == MulRun) begin
        HI <= prodFinal[2*NBits-1:NBits];
        LO <= prodFinal[NBits-1:0];
      end else begin
        HI <= remFinal;
        LO <= quoFinal;
      end
    end else if (accept & isMthi) begin
      HI <= rsFwd;
    end else if (accept & isMtlo) begin
      LO <= rsFwd;
    end
  end

  assign ALUResult = isMfhi ? HI : (isMflo ? LO : aluOut);
  assign Zero      = (aluOut == '0);

endmodule

// File: tb/tb_ex_stage_muldiv.sv
// Randomised bench for ex_stage_muldiv against a transaction-level model of
// the ALU and the mul/div unit (results via plain 64-bit arithmetic).
module tb_ex_stage_muldiv;
  localparam int NBits = 32;

  logic        clk = 1'b0;
  logic        reset, ShamtSelector, ALUSrc, RType, Flush;
  logic [31:0] ReadData1, ReadData2, ShamtExtend, InmmediateExtend, PC_4;
  logic [31:0] ALUMemOrPCData, MEM_ALUResult;
  logic [2:0]  ALUOp;
  logic [5:0]  ALUFunction;
  logic [25:0] JumpNoShifted;
  logic [1:0]  ForwardA, ForwardB;
  logic [31:0] WriteData, BranchAddress, JumpAddress, ALUResult, HI, LO;
  logic        Zero, MulDivBusy, Stall;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mHi, mLo, pendHi, pendLo;
  int          busyLeft = 0;
  int          n;

  logic [5:0] functList [0:24] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
    6'h26, 6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
    6'h08, 6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B};

  ex_stage_muldiv #(.NBits(NBits)) dut (
    .clk(clk), .reset(reset), .ShamtSelector(ShamtSelector), .ALUSrc(ALUSrc),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .ShamtExtend(ShamtExtend),
    .InmmediateExtend(InmmediateExtend), .ALUOp(ALUOp), .ALUFunction(ALUFunction),
    .RType(RType), .Flush(Flush), .JumpNoShifted(JumpNoShifted), .PC_4(PC_4),
    .ForwardA(ForwardA), .ForwardB(ForwardB), .ALUMemOrPCData(ALUMemOrPCData),
    .MEM_ALUResult(MEM_ALUResult), .WriteData(WriteData),
    .BranchAddress(BranchAddress), .JumpAddress(JumpAddress),
    .ALUResult(ALUResult), .Zero(Zero), .MulDivBusy(MulDivBusy),
    .Stall(Stall), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fwdVal(input logic [1:0] sel, input logic [31:0] rf);
    case (sel)
      2'd1:    return ALUMemOrPCData;
      2'd2:    return MEM_ALUResult;
      default: return rf;
    endcase
  endfunction

  function automatic logic [31:0] addOp(input logic [31:0] a, input logic [31:0] b);
    return a + b;
  endfunction

  function automatic logic [31:0] refAlu(input logic [2:0] op, input logic [5:0] f,
                                         input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(a[4:0]);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return {b[15:0], 16'h0000};
      3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6: return a ^ b;
      default: begin
        case (f)
          6'h22, 6'h23: return a - b;
          6'h24: return a & b;
          6'h25: return a | b;
          6'h26: return a ^ b;
          6'h27: return ~(a | b);
          6'h2A: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'h2B: return (a < b) ? 32'd1 : 32'd0;
          6'h00, 6'h04: return b << sh;
          6'h02, 6'h06: return b >> sh;
          6'h03, 6'h07: return 32'($signed(b) >>> sh);
          default: return addOp(a, b);
        endcase
      end
    endcase
  endfunction

  function automatic bit isMd(input logic [5:0] f);
    return (f inside {6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B});
  endfunction

  task automatic refMulDiv(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt,
                           output logic [31:0] hi, output logic [31:0] lo);
    longint      ps;
    logic [63:0] pu;
    int          a, b;
    a = $signed(rs);
    b = $signed(rt);
    case (f)
      6'h18: begin
        ps = longint'(a) * longint'(b);
        hi = ps[63:32]; lo = ps[31:0];
      end
      6'h19: begin
        pu = {32'h0, rs} * {32'h0, rt};
        hi = pu[63:32]; lo = pu[31:0];
      end
      6'h1A: begin
        if (rt == 32'h0) begin
          lo = 32'hFFFFFFFF; hi = rs;
        end else if (rs == 32'h80000000 && rt == 32'hFFFFFFFF) begin
          lo = 32'h80000000; hi = 32'h0;
        end else begin
          lo = 32'(a / b); hi = 32'(a % b);
        end
      end
      default: begin
        if (rt == 32'h0) begin
          lo = 32'hFFFFFFFF; hi = rs;
        end else begin
          lo = rs / rt; hi = rs % rt;
        end
      end
    endcase
  endtask

  task automatic checkAll();
    logic [31:0] rs, rt, a, b, alu, expRes;
    bit          md;
    rs  = fwdVal(ForwardA, ReadData1);
    rt  = fwdVal(ForwardB, ReadData2);
    a   = ShamtSelector ? ShamtExtend : rs;
    b   = ALUSrc ? InmmediateExtend : rt;
    alu = refAlu(ALUOp, ALUFunction, a, b);
    md  = RType && isMd(ALUFunction);
    expRes = alu;
    if (RType && ALUFunction == 6'h10) expRes = mHi;
    if (RType && ALUFunction == 6'h12) expRes = mLo;
    checkOutput("ALUResult", ALUResult, expRes);
    checkOutput("Zero", {31'b0, Zero}, {31'b0, (alu == 32'h0)});
    checkOutput("WriteData", WriteData, rt);
    checkOutput("BranchAddress", BranchAddress, PC_4 + InmmediateExtend * 4);
    checkOutput("JumpAddress", JumpAddress, {PC_4[31:28], JumpNoShifted, 2'b00});
    checkOutput("MulDivBusy", {31'b0, MulDivBusy}, {31'b0, (busyLeft > 0)});
    checkOutput("Stall", {31'b0, Stall}, {31'b0, (busyLeft > 0) && md});
    checkOutput("HI", HI, mHi);
    checkOutput("LO", LO, mLo);
  endtask

  task automatic updateModel();
    logic [31:0] rs, rt;
    rs = fwdVal(ForwardA, ReadData1);
    rt = fwdVal(ForwardB, ReadData2);
    if (reset) begin
      mHi = 32'h0; mLo = 32'h0; busyLeft = 0;
    end else if (busyLeft > 0) begin
      busyLeft--;
      if (busyLeft == 0) begin
        mHi = pendHi; mLo = pendLo;
      end
    end else if (RType && !Flush) begin
      case (ALUFunction)
        6'h11: mHi = rs;
        6'h13: mLo = rs;
        6'h18, 6'h19, 6'h1A, 6'h1B: begin
          refMulDiv(ALUFunction, rs, rt, pendHi, pendLo);
          busyLeft = NBits;
        end
        default: ;
      endcase
    end
  endtask

  task automatic runCycle();
    @(negedge clk);
    checkAll();
    @(posedge clk);
    updateModel();
    #1;
  endtask

  task automatic setNop();
    RType = 1'b0; ALUOp = 3'd0; ALUFunction = 6'h20; Flush = 1'b0;
    ShamtSelector = 1'b0; ALUSrc = 1'b0; ForwardA = 2'd0; ForwardB = 2'd0;
  endtask

  task automatic applyStimulus(input logic [5:0] f, input logic [31:0] rs,
                               input logic [31:0] rt, input logic flush);
    RType = 1'b1; ALUOp = 3'd7; ALUFunction = f; Flush = flush;
    ReadData1 = rs; ReadData2 = rt; ForwardA = 2'd0; ForwardB = 2'd0;
    ShamtSelector = 1'b0; ALUSrc = 1'b0;
  endtask

  task automatic runToIdle(output int cyc);
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      if (!MulDivBusy) break;
      cyc++;
      runCycle();
    end
  endtask

  function automatic logic [31:0] randVal();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 20));
      4: return -32'($urandom_range(1, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic randomizeInputs();
    RType         = ($urandom_range(0, 3) != 0);
    ALUOp         = RType ? 3'd7 : 3'($urandom_range(0, 7));
    ALUFunction   = functList[$urandom_range(0, 24)];
    Flush         = ($urandom_range(0, 7) == 0);
    ShamtSelector = ($urandom_range(0, 3) == 0);
    ALUSrc        = ($urandom_range(0, 3) == 0);
    ForwardA      = 2'($urandom_range(0, 3));
    ForwardB      = 2'($urandom_range(0, 3));
    ReadData1     = randVal();
    ReadData2     = randVal();
    ALUMemOrPCData = randVal();
    MEM_ALUResult = randVal();
    ShamtExtend   = 32'($urandom_range(0, 31));
    InmmediateExtend = randVal();
    PC_4          = 32'($urandom);
    JumpNoShifted = 26'($urandom);
    reset         = ($urandom_range(0, 299) == 0);
  endtask

  initial begin
    reset = 1'b1;
    setNop();
    ReadData1 = 32'h0; ReadData2 = 32'h0; ShamtExtend = 32'h0;
    InmmediateExtend = 32'h0; PC_4 = 32'h0; JumpNoShifted = 26'h0;
    ALUMemOrPCData = 32'h0; MEM_ALUResult = 32'h0;
    @(posedge clk);
    mHi = 32'h0; mLo = 32'h0; busyLeft = 0;
    #1;
    checkOutput("rstHI", HI, 32'h0);
    checkOutput("rstLO", LO, 32'h0);
    checkOutput("rstBusy", {31'b0, MulDivBusy}, 32'h0);
    checkOutput("rstStall", {31'b0, Stall}, 32'h0);
    runCycle();
    reset = 1'b0;

    RType = 1'b1; ALUOp = 3'd7; ALUFunction = 6'h20; ForwardA = 2'd2;
    MEM_ALUResult = 32'd5; ReadData2 = 32'd3; PC_4 = 32'h100; InmmediateExtend = 32'd4;
    #1;
    checkOutput("fwdAdd", ALUResult, 32'd8);
    checkOutput("fwdZero", {31'b0, Zero}, 32'h0);
    checkOutput("branchAddr", BranchAddress, 32'h110);
    runCycle();

    applyStimulus(6'h18, -32'd3, 32'd7, 1'b0);
    runCycle();
    setNop();
    runToIdle(n);
    checkOutput("multBusyCycles", 32'(n), 32'd32);
    checkOutput("multHi", HI, 32'hFFFFFFFF);
    checkOutput("multLo", LO, 32'hFFFFFFEB);

    applyStimulus(6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    runCycle(); setNop(); runToIdle(n);
    checkOutput("multuHi", HI, 32'hFFFFFFFE);
    checkOutput("multuLo", LO, 32'h00000001);

    applyStimulus(6'h1A, -32'd7, 32'd2, 1'b0);
    runCycle(); setNop(); runToIdle(n);
    checkOutput("divLo", LO, 32'hFFFFFFFD);
    checkOutput("divHi", HI, 32'hFFFFFFFF);

    applyStimulus(6'h1B, 32'd7, 32'd0, 1'b0);
    runCycle(); setNop(); runToIdle(n);
    checkOutput("divuZeroBusy", 32'(n), 32'd32);
    checkOutput("divuZeroLo", LO, 32'hFFFFFFFF);
    checkOutput("divuZeroHi", HI, 32'd7);

    applyStimulus(6'h1A, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    runCycle(); setNop(); runToIdle(n);
    checkOutput("divOvfLo", LO, 32'h80000000);
    checkOutput("divOvfHi", HI, 32'h0);

    applyStimulus(6'h18, 32'd1000, -32'd2, 1'b0);
    runCycle(); setNop(); runCycle();
    applyStimulus(6'h12, 32'h0, 32'h0, 1'b0);
    #1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!Stall) break;
      n++;
      runCycle();
    end
    checkOutput("mfloStallCycles", 32'(n), 32'd31);
    checkOutput("mfloResult", ALUResult, 32'hFFFFF830);
    runCycle();

    applyStimulus(6'h19, 32'h10, 32'h20, 1'b0);
    runCycle();
    setNop(); RType = 1'b1; ALUOp = 3'd7; ALUFunction = 6'h20;
    #1;
    checkOutput("addNoStall", {31'b0, Stall}, 32'h0);
    runToIdle(n);
    checkOutput("multuSmallLo", LO, 32'h200);

    applyStimulus(6'h11, 32'h12345678, 32'h0, 1'b0);
    runCycle();
    checkOutput("mthi", HI, 32'h12345678);
    applyStimulus(6'h13, 32'hCAFEF00D, 32'h0, 1'b0);
    runCycle();
    checkOutput("mtlo", LO, 32'hCAFEF00D);

    applyStimulus(6'h18, 32'd5, 32'd5, 1'b1);
    runCycle();
    checkOutput("flushBusy", {31'b0, MulDivBusy}, 32'h0);
    checkOutput("flushHi", HI, 32'h12345678);
    checkOutput("flushLo", LO, 32'hCAFEF00D);

    applyStimulus(6'h1A, 32'd100, 32'd3, 1'b0);
    runCycle(); setNop();
    repeat (9) runCycle();
    reset = 1'b1;
    runCycle();
    reset = 1'b0;
    checkOutput("midRstBusy", {31'b0, MulDivBusy}, 32'h0);
    checkOutput("midRstHi", HI, 32'h0);
    checkOutput("midRstLo", LO, 32'h0);

    for (int i = 0; i < 1500; i++) begin
      randomizeInputs();
      runCycle();
    end
    reset = 1'b0;
    setNop();
    runCycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
